// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART TX write-port arbiter: FSM encoding,
// byte width and pointer wrap helper.
package uart_arb_pkg;

    localparam int DATA_W = 8;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    // Next round-robin start position after index idx, wrapping at modulus.
    function automatic int wrap_inc(input int idx, input int modulus);
        return (idx + 1 >= modulus) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/uart_arb_rr_picker.sv
// Combinational rotate-search: first asserted valid bit at or above ptr,
// wrapping around, reported as both a one-hot vector and an index.
module uart_arb_rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] pick_onehot,
    output logic [IDX_W-1:0]   pick_idx,
    output logic               any_valid
);

    logic found;

    always_comb begin
        int         sum;
        logic [IDX_W-1:0] cand_idx;
        found    = 1'b0;
        pick_idx = '0;
        sum      = 0;
        cand_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = int'(ptr) + i;
            if (sum >= NUM_REQ) begin
                sum = sum - NUM_REQ;
            end
            cand_idx = IDX_W'(sum);
            if (!found && valid[cand_idx]) begin
                found    = 1'b1;
                pick_idx = cand_idx;
            end
        end
    end

    assign any_valid = found;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
            assign pick_onehot[gi] = found && (pick_idx == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter sharing the UART TX FIFO write port among
// NUM_REQ requesters, with an idle timeout that reclaims a stalled grant.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int IDLE_TIMEOUT = 64
) (
    input  logic                      i_uart_arb_clk,
    input  logic                      i_uart_arb_rst,
    input  logic [NUM_REQ-1:0]        i_uart_arb_req_valid,
    input  logic [DATA_W*NUM_REQ-1:0] i_uart_arb_req_data,
    input  logic [NUM_REQ-1:0]        i_uart_arb_req_last,
    output logic [NUM_REQ-1:0]        o_uart_arb_req_ready,
    input  logic                      i_uart_arb_fifo_full,
    output logic [DATA_W-1:0]         o_uart_arb_tx_pdata,
    output logic                      o_uart_arb_tx_valid,
    output logic [NUM_REQ-1:0]        o_uart_arb_grant,
    output logic                      o_uart_arb_timeout
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;

    arb_state_e         state_reg;
    logic [NUM_REQ-1:0] grant_reg;
    logic [IDX_W-1:0]   owner_idx_reg;
    logic [IDX_W-1:0]   rr_ptr_reg;
    logic [IDX_W-1:0]   rr_ptr_next;
    logic [CNT_W-1:0]   timeout_cnt_reg;
    logic               timeout_reg;

    logic [NUM_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0]   pick_idx;
    logic               any_valid;

    logic [DATA_W-1:0]  req_data_arr [NUM_REQ];
    logic               in_grant;
    logic               owner_valid;
    logic               owner_last;
    logic [DATA_W-1:0]  owner_data;
    logic               xfer;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign req_data_arr[gi] = i_uart_arb_req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    uart_arb_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .valid       (i_uart_arb_req_valid),
        .ptr         (rr_ptr_reg),
        .pick_onehot (pick_onehot),
        .pick_idx    (pick_idx),
        .any_valid   (any_valid)
    );

    assign in_grant    = (state_reg == ARB_GRANT);
    assign owner_valid = i_uart_arb_req_valid[owner_idx_reg];
    assign owner_last  = i_uart_arb_req_last[owner_idx_reg];
    assign owner_data  = req_data_arr[owner_idx_reg];
    assign rr_ptr_next = IDX_W'(wrap_inc(int'(owner_idx_reg), NUM_REQ));

    // Reset masks the strobes so a packet cut by reset never leaks a byte.
    assign xfer                = in_grant && owner_valid && !i_uart_arb_fifo_full
                                 && !i_uart_arb_rst;
    assign o_uart_arb_tx_valid = xfer;
    assign o_uart_arb_tx_pdata = in_grant ? owner_data : '0;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign o_uart_arb_req_ready[gi] = grant_reg[gi] && !i_uart_arb_fifo_full
                                              && !i_uart_arb_rst;
        end
    endgenerate

    assign o_uart_arb_grant   = grant_reg;
    assign o_uart_arb_timeout = timeout_reg;

    always_ff @(posedge i_uart_arb_clk) begin
        if (i_uart_arb_rst) begin
            state_reg       <= ARB_IDLE;
            grant_reg       <= '0;
            owner_idx_reg   <= '0;
            rr_ptr_reg      <= '0;
            timeout_cnt_reg <= '0;
            timeout_reg     <= 1'b0;
        end else begin
            timeout_reg <= 1'b0;
            case (state_reg)
                ARB_IDLE: begin
                    timeout_cnt_reg <= '0;
                    if (any_valid) begin
                        state_reg     <= ARB_GRANT;
                        grant_reg     <= pick_onehot;
                        owner_idx_reg <= pick_idx;
                    end
                end
                ARB_GRANT: begin
                    if (xfer && owner_last) begin
                        state_reg       <= ARB_IDLE;
                        grant_reg       <= '0;
                        rr_ptr_reg      <= rr_ptr_next;
                        timeout_cnt_reg <= '0;
                    end else if (owner_valid) begin
                        // A full-FIFO stall with data pending is not idleness.
                        timeout_cnt_reg <= '0;
                    end else if (timeout_cnt_reg == CNT_W'(IDLE_TIMEOUT - 1)) begin
                        state_reg       <= ARB_IDLE;
                        grant_reg       <= '0;
                        rr_ptr_reg      <= rr_ptr_next;
                        timeout_cnt_reg <= '0;
                        timeout_reg     <= 1'b1;
                    end else begin
                        timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= ARB_IDLE;
                    grant_reg <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (NUM_REQ=4, IDLE_TIMEOUT=64).
module tb_uart_tx_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        fifo_full;
    logic [7:0]  tx_pdata;
    logic        tx_valid;
    logic [3:0]  grant;
    logic        timeout;

    int n_assert = 0;
    int n_fail   = 0;
    int nb[4];

    uart_tx_arbiter #(
        .NUM_REQ      (4),
        .IDLE_TIMEOUT (64)
    ) dut (
        .i_uart_arb_clk       (clk),
        .i_uart_arb_rst       (rst),
        .i_uart_arb_req_valid (req_valid),
        .i_uart_arb_req_data  (req_data),
        .i_uart_arb_req_last  (req_last),
        .o_uart_arb_req_ready (req_ready),
        .i_uart_arb_fifo_full (fifo_full),
        .o_uart_arb_tx_pdata  (tx_pdata),
        .o_uart_arb_tx_valid  (tx_valid),
        .o_uart_arb_grant     (grant),
        .o_uart_arb_timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packet pattern for the alternation test: byte = {req, byte#}, last on odd byte.
    task automatic drive_rr();
        for (int k = 0; k < 4; k++) begin
            req_data[8*k +: 8] = {4'(k), 4'(nb[k])};
            req_last[k]        = nb[k][0];
        end
    endtask

    initial begin
        int own;
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        fifo_full = 1'b0;
        tick();
        chk("rst_grant", grant, 0);
        chk("rst_txv", tx_valid, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_pdata", tx_pdata, 0);
        chk("rst_timeout", timeout, 0);
        rst = 1'b0;

        // Single requester 1, 3-byte packet.
        req_valid = 4'b0010; req_data[15:8] = 8'h41; req_last = 4'b0000; #1;
        chk("t1_idle_grant", grant, 0);
        chk("t1_idle_txv", tx_valid, 0);
        tick();
        chk("t1_grant", grant, 4'b0010);
        chk("t1_ready", req_ready, 4'b0010);
        chk("t1_b0_txv", tx_valid, 1);
        chk("t1_b0_data", tx_pdata, 8'h41);
        tick();
        req_data[15:8] = 8'h42; #1;
        chk("t1_b1_txv", tx_valid, 1);
        chk("t1_b1_data", tx_pdata, 8'h42);
        tick();
        req_data[15:8] = 8'h43; req_last = 4'b0010; #1;
        chk("t1_b2_txv", tx_valid, 1);
        chk("t1_b2_data", tx_pdata, 8'h43);
        tick();
        req_valid = 4'b0000; req_last = 4'b0000; #1;
        chk("t1_after_grant", grant, 0);
        chk("t1_after_txv", tx_valid, 0);

        // Pointer is now 2: with reqs 1 and 2 both valid, 2 must win.
        req_valid = 4'b0110; req_data[15:8] = 8'h66; req_data[23:16] = 8'h55;
        req_last = 4'b0110;
        tick();
        chk("ptr2_grant", grant, 4'b0100);
        chk("ptr2_data", tx_pdata, 8'h55);
        tick();
        req_valid = 4'b0010; #1;
        chk("ptr2_bubble", grant, 0);
        chk("ptr2_bubble_ready", req_ready, 0);
        tick();
        chk("ptr3_grant", grant, 4'b0010);
        chk("ptr3_data", tx_pdata, 8'h66);
        tick();
        req_valid = '0; req_last = '0;

        // Reset so pointer is 0, then reqs 0 and 2 alternate 2-byte packets.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) nb[k] = 0;
        req_valid = 4'b0101;
        for (int p = 0; p < 4; p++) begin
            own = (p % 2 == 0) ? 0 : 2;
            drive_rr(); #1;
            chk("rr_bubble_grant", grant, 0);
            chk("rr_bubble_txv", tx_valid, 0);
            tick();
            for (int b = 0; b < 2; b++) begin
                drive_rr(); #1;
                chk("rr_grant", grant, 32'(1) << own);
                chk("rr_txv", tx_valid, 1);
                chk("rr_data", tx_pdata, 32'((own << 4) | ((p / 2) * 2 + b)));
                tick();
                nb[own]++;
            end
        end
        req_valid = '0; req_last = '0;

        // Requester 3 (pointer 3): fifo_full for 10 cycles mid-packet, then last byte stalled.
        req_valid = 4'b1000; req_data[31:24] = 8'h30;
        tick();
        chk("ff_grant", grant, 4'b1000);
        chk("ff_b0", tx_pdata, 8'h30);
        tick();
        req_data[31:24] = 8'h31; fifo_full = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("ff_ready", req_ready, 0);
            chk("ff_txv", tx_valid, 0);
            chk("ff_timeout", timeout, 0);
            chk("ff_hold_grant", grant, 4'b1000);
            tick();
        end
        fifo_full = 1'b0; #1;
        chk("ff_resume_txv", tx_valid, 1);
        chk("ff_resume_data", tx_pdata, 8'h31);
        tick();
        req_data[31:24] = 8'h32; #1;
        chk("ff_b2", tx_pdata, 8'h32);
        tick();
        req_data[31:24] = 8'h33; req_last = 4'b1000; fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("last_stall_grant", grant, 4'b1000);
            chk("last_stall_txv", tx_valid, 0);
            tick();
        end
        fifo_full = 1'b0; #1;
        chk("last_accept_txv", tx_valid, 1);
        chk("last_accept_data", tx_pdata, 8'h33);
        tick();
        req_valid = '0; req_last = '0; #1;
        chk("last_idle_grant", grant, 0);

        // Timeout: owner 0 goes quiet after one byte while requester 3 waits.
        req_valid = 4'b0001; req_data[7:0] = 8'hA0;
        tick();
        chk("to_grant", grant, 4'b0001);
        chk("to_b0", tx_pdata, 8'hA0);
        tick();
        req_valid = 4'b1000; req_data[31:24] = 8'hB0; req_last = 4'b1000;
        for (int i = 0; i < 64; i++) begin
            #1;
            chk("to_hold_grant", grant, 4'b0001);
            chk("to_hold_ready", req_ready, 4'b0001);
            chk("to_no_pulse", timeout, 0);
            tick();
        end
        chk("to_release_grant", grant, 0);
        chk("to_pulse", timeout, 1);
        tick();
        chk("to_pulse_single", timeout, 0);
        chk("to_next_grant", grant, 4'b1000);
        chk("to_next_data", tx_pdata, 8'hB0);
        chk("to_next_txv", tx_valid, 1);
        tick();
        req_valid = '0; req_last = '0;

        // Reset at byte 2 of a 4-byte packet from requester 1.
        req_valid = 4'b0010; req_data[15:8] = 8'h10;
        tick();
        chk("rm_grant", grant, 4'b0010);
        chk("rm_b0", tx_pdata, 8'h10);
        tick();
        req_data[15:8] = 8'h11; #1;
        chk("rm_b1", tx_pdata, 8'h11);
        tick();
        req_data[15:8] = 8'h12; req_valid = 4'b0011; req_data[7:0] = 8'h0F;
        req_last = 4'b0001; rst = 1'b1; #1;
        chk("rm_rst_txv", tx_valid, 0);
        chk("rm_rst_ready", req_ready, 0);
        tick();
        rst = 1'b0; #1;
        chk("rm_post_grant", grant, 0);
        chk("rm_post_txv", tx_valid, 0);
        tick();
        chk("rm_tie_grant", grant, 4'b0001);
        chk("rm_tie_data", tx_pdata, 8'h0F);
        chk("rm_tie_txv", tx_valid, 1);
        tick();
        req_valid = 4'b0010; req_last = 4'b0000; #1;
        chk("rm_bubble", grant, 0);
        tick();
        chk("rm_req1_grant", grant, 4'b0010);
        req_valid = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single byte-write port of the UART TX peripheral (pdata/valid in, fifo_full out) among NUM_REQ on-chip requesters (e.g. core store path, debug printf, trap logger). Each requester gets an atomic packet grant: its bytes reach the TX FIFO contiguously until it flags the last byte. An idle timeout releases the grant if a requester stalls. Sits in the i_uart_clk domain between the requesters and the peripheral's write side.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- IDLE_TIMEOUT, 64, consecutive granted-but-not-valid cycles before forced release (≥2)
- i_uart_arb_clk  input  1  peripheral write clock (same as i_uart_clk)
- i_uart_arb_rst  input  1  reset; synchronous and active-high (one clock, synchronous active-high reset)
- i_uart_arb_req_valid  input  NUM_REQ  per-requester byte valid
- i_uart_arb_req_data  input  8*NUM_REQ  per-requester byte, requester k at bits [8k+7:8k]
- i_uart_arb_req_last  input  NUM_REQ  byte is final of packet
- o_uart_arb_req_ready  output  NUM_REQ  per-requester accept
- i_uart_arb_fifo_full  input  1  TX FIFO full from peripheral
- o_uart_arb_tx_pdata  output  8  byte to peripheral
- o_uart_arb_tx_valid  output  1  write strobe to peripheral
- o_uart_arb_grant  output  NUM_REQ  one-hot current owner, 0 when idle
- o_uart_arb_timeout  output  1  one-cycle pulse on forced release

## Operation
- States: IDLE, GRANT. Reset → IDLE, grant 0, rr pointer 0, timeout counter 0, o_uart_arb_timeout 0; combinational outputs therefore 0 (ready 0, tx_valid 0, pdata 0).
- IDLE: if any valid, pick first asserting requester searching from rr pointer upward with wrap; register grant, go GRANT. No valid → stay.
- GRANT, owner g: ready[g] = !fifo_full; all other ready 0. tx_valid = valid[g] & !fifo_full; tx_pdata = data[g] (0 when idle). Transfer = valid[g] & ready[g].
- Transfer with last[g]=1 → IDLE next cycle, rr pointer = (g+1) mod NUM_REQ.
- Timeout counter: increments each GRANT cycle with valid[g]=0; clears on any cycle with valid[g]=1 (including fifo_full stalls, which never time out); clears on grant change. Reaching IDLE_TIMEOUT-1 while valid[g]=0 → IDLE next cycle, pulse o_uart_arb_timeout, rr pointer = g+1. Packet remainder from g after that competes as a new packet.
- Requester lowering valid mid-packet without last: legal; grant held until last or timeout.
- Reset mid-packet: all state cleared in the cycle after reset sampled; no partial byte emitted during reset.
- Unowned valid bits are ignored; no byte ever dropped or duplicated.

## Timing
- Request at cycle N in IDLE → grant at N+1; first byte may transfer at N+1.
- Sustained throughput 1 byte/cycle while !fifo_full.
- Last byte at cycle M → IDLE at M+1, next grant at M+2 (one bubble per packet).
- fifo_full is combinationally masked into ready and tx_valid same cycle; zero-latency backpressure.
- Timeout: valid[g] low from cycle T → release at T+IDLE_TIMEOUT, pulse in that cycle.

## Structure
- Shared package/header uart_arb_pkg: state encoding (IDLE=0, GRANT=1), data width constant 8.
- Sub-module uart_arb_rr_picker: combinational rotate-search, inputs valid vector + pointer, outputs one-hot pick and index.
- Top: state/grant/pointer/counter registers, output muxes.

## Test plan
- Single requester 1 sends 3-byte packet 0x41,0x42,0x43(last) from idle → grant=0010 at N+1, three consecutive tx_valid with those bytes, IDLE after, pointer=2.
- Reqs 0 and 2 both valid continuously, 2-byte packets → grants alternate 0,2,0,2; bytes never interleave within a packet; one bubble between packets.
- fifo_full held 10 cycles mid-packet with valid high → ready and tx_valid 0 for those cycles, no timeout, transfer resumes next cycle after full drops.
- Owner drops valid mid-packet for IDLE_TIMEOUT=64 cycles → release at cycle 64, timeout pulse single cycle, pending requester 3 granted next cycle.
- Reset asserted at byte 2 of 4 → next cycle grant 0, tx_valid 0, pointer 0; after release, requester 0 wins a tie with 1.
- Last byte stalled by fifo_full → grant held until accepted; IDLE exactly one cycle after acceptance.
